// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared op codes, FSM state encoding and a small magnitude helper for
// the multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Magnitude of a 32-bit value when treated as signed; 32'h80000000 maps
    // to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// One bit per cycle over 32 RUN cycles, then one FIN cycle for sign
// correction and the HI/LO write.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous active-high reset
//   start - operation request (accepted only when idle)
//   op    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b  - rs / rt operands, sampled only at the accepting edge
//   busy  - high while RUN or FIN
//   done  - one-cycle pulse when hi/lo were updated by a mul/div
//   hi,lo - result registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state, state_n;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               md_req;
    logic               sgn_op;
    logic [WIDTH:0]     lhs, rhs, sum;
    logic               take;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign md_req = start && (op[2] == 1'b0);
    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
    assign busy   = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (md_req) state_n = S_RUN;
            S_RUN:   if (cnt == 5'd31) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Single 33-bit adder/subtractor. Multiply adds the multiplicand into the
    // upper half; divide subtracts the divisor from the upper half shifted
    // left by one. For divide, a set acc[63] means the shifted partial
    // remainder is already >= 2^32 and thus larger than any divisor, so the
    // subtraction is always taken and its low 32 bits are exact.
    always_comb begin
        lhs = is_div ? {1'b0, acc[2*WIDTH-2:WIDTH-1]} : {1'b0, acc[2*WIDTH-1:WIDTH]};
        rhs = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
        sum = lhs + rhs + {{WIDTH{1'b0}}, is_div};
        take = acc[2*WIDTH-1] | ~sum[WIDTH];
        if (is_div)
            acc_step = {(take ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                        acc[WIDTH-2:0], take};
        else if (acc[0])
            acc_step = {sum, acc[WIDTH-1:1]};
        else
            acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end

    // Sign correction applied during FIN
    always_comb begin
        prod = neg_q ? (~acc + 64'd1) : acc;
        quo  = neg_q ? (~acc[WIDTH-1:0] + 32'd1) : acc[WIDTH-1:0];
        rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 32'd1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) hi <= a;
                        if (op == OP_MTLO) lo <= a;
                        if (md_req) begin
                            acc    <= {{WIDTH{1'b0}}, mag32(a, sgn_op)};
                            opnd   <= mag32(b, sgn_op);
                            cnt    <= '0;
                            is_div <= op[1];
                            // Divide by zero keeps the all-ones quotient
                            // unnegated; the remainder then equals a.
                            neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                            neg_r  <= sgn_op && op[1] && a[WIDTH-1];
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                end
                S_FIN: begin
                    if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The parameter list SHALL be: WIDTH, 32, operand/result width (only 32 is supported).
REQ-002 The ports SHALL be, in order:
- clk    in   1   rising-edge clock.
- clr    in   1   synchronous, active-high reset.
- start  in   1   operation request, sampled on the clk edge.
- op     in   3   operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
- a      in   32  rs operand, taken from register file r_data1.
- b      in   32  rt operand, taken from register file r_data2.
- busy   out  1   multi-cycle operation in progress.
- done   out  1   one-cycle pulse: hi/lo were just updated by MULT/MULTU/DIV/DIVU.
- hi     out  32  HI register; MFHI source.
- lo     out  32  LO register; MFLO source.
REQ-003 The block SHALL use one clock, clk; clr SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and FIN. busy SHALL be 1 exactly when the state is RUN or FIN.
REQ-005 start SHALL be accepted only in IDLE; start during RUN or FIN SHALL be ignored, with no queuing.
REQ-006 MTHI/MTLO accepted in IDLE SHALL write a into hi/lo at that same edge; the FSM SHALL stay in IDLE and done SHALL remain 0.
REQ-007 On an accepted MULT/MULTU/DIV/DIVU, the block SHALL latch the operands at the start edge:
- magnitudes for signed ops;
- a sign-correction flag;
- counter = 0;
- next state RUN.
REQ-008 RUN SHALL last exactly 32 cycles, one bit per cycle: shift-add for multiply, restoring subtract-shift for divide. The counter SHALL be 5 bits and leave RUN when the counter is 31.
REQ-009 FIN SHALL last one cycle and apply sign correction. At the FIN exit edge the block SHALL:
- write hi/lo;
- set done = 1 for one cycle;
- return to IDLE.
REQ-010 Latency: if start is sampled in cycle 0, then done = 1, busy = 0 and the new hi/lo SHALL be visible in cycle 34.
REQ-011 A new start SHALL be accepted in the same cycle that done = 1.
REQ-012 hi/lo SHALL hold their previous values throughout RUN and FIN.
REQ-013 Multiply results: MULT SHALL produce the signed 64-bit product and MULTU the unsigned 64-bit product, with hi = bits 63:32 and lo = bits 31:0.
REQ-014 Divide results: lo = quotient truncated toward zero; hi = remainder, carrying the dividend's sign (DIV) or unsigned (DIVU).
REQ-015 Divide by zero (b = 0), for both DIV and DIVU, SHALL give lo = 32'hFFFFFFFF and hi = a, with full latency.
REQ-016 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo = 32'h80000000 and hi = 0.
REQ-017 Op codes 110 and 111 SHALL be ignored: no state change and no register write.
REQ-018 Operand inputs SHALL NOT be observed after the start edge; a and b may change freely during busy.

Reset
REQ-019 When clr = 1 at a clk edge, the block SHALL set: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0.
REQ-020 clr SHALL take priority over start and over any in-flight operation.
REQ-021 An aborted operation SHALL produce no done pulse.

Structure
REQ-022 Op codes and FSM state encodings SHALL reside in a shared include file, muldiv_defs.v, which is also used by control.v for decode.
REQ-023 The block SHALL be a single module with no sub-module.
REQ-024 The datapath SHALL consist of a 64-bit accumulator/remainder-quotient register, a 32-bit operand register and one 33-bit adder/subtractor, shared between multiply and divide.

Verification
REQ-025 MULTU a = FFFFFFFF, b = FFFFFFFF -> cycle 34: hi = FFFFFFFE, lo = 00000001, done = 1 for one cycle.
REQ-026 MULT a = FFFFFFFD (-3), b = 00000007 -> hi = FFFFFFFF, lo = FFFFFFEB (-21).
REQ-027 DIV a = FFFFFFF9 (-7), b = 00000002 -> lo = FFFFFFFD, hi = FFFFFFFF; then DIVU a = 00000064, b = 0 -> lo = FFFFFFFF, hi = 00000064.
REQ-028 Start a DIV, then pulse start with MTHI in cycle 5 -> MTHI ignored. Assert clr in cycle 10 -> cycle 11: busy = 0, hi = lo = 0; no done in cycles 11-40.
REQ-029 MTHI a = 12345678 then MTLO a = 9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each request, busy = 0, done = 0 throughout.
REQ-030 Back-to-back: a second MULTU issued in the done cycle of the first -> accepted; second done exactly 34 cycles later.
